// File: rtl/bus_poll_scheduler.sv
// Round-robin CAN bus poll scheduler: one poll per trigger, valid/ack handshake,
// completion or timeout, with a saturating count of triggers dropped while busy.
module bus_poll_scheduler #(
  parameter int NBUS    = 8,
  parameter int BUS_W   = 3,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             request_trig,
  input  logic [NBUS-1:0]  bus_enable,
  output logic             req_valid,
  output logic [BUS_W-1:0] req_bus_id,
  input  logic             req_ack,
  input  logic             resp_done,
  input  logic             resp_err,
  output logic             done_pulse,
  output logic             err_pulse,
  output logic             timeout_pulse,
  output logic             busy,
  output logic [7:0]       missed_trig_cnt
);

  typedef enum logic [1:0] {IDLE, SELECT, REQUEST, WAIT_DONE} state_t;

  state_t           state, state_nxt;
  logic [BUS_W-1:0] ptr, sel_idx;
  logic             sel_found;
  logic [7:0]       timer;
  logic             tmo_hit;
  logic             done_nxt, err_nxt, tmo_nxt;

  assign tmo_hit = (timer == 8'(TIMEOUT - 1));

  // Search ptr+1 .. ptr+NBUS so that ptr itself is the last candidate.
  always_comb begin
    int               j;
    logic [BUS_W-1:0] idx;
    sel_idx   = '0;
    sel_found = 1'b0;
    j         = 0;
    idx       = '0;
    for (int i = 1; i <= NBUS; i++) begin
      j   = (int'(ptr) + i) % NBUS;
      idx = BUS_W'(j);
      if (!sel_found && bus_enable[idx]) begin
        sel_idx   = idx;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE:
        if (request_trig && (|bus_enable)) state_nxt = SELECT;
      SELECT:
        state_nxt = sel_found ? REQUEST : IDLE;
      REQUEST:
        if (tmo_hit) begin
          state_nxt = IDLE;
          tmo_nxt   = 1'b1;
        end else if (req_ack) begin
          state_nxt = WAIT_DONE;
        end
      WAIT_DONE:
        if (resp_done) begin
          state_nxt = IDLE;
          err_nxt   = resp_err;
          done_nxt  = !resp_err;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          tmo_nxt   = 1'b1;
        end
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= BUS_W'(NBUS - 1);
      req_bus_id      <= '0;
      timer           <= '0;
      req_valid       <= 1'b0;
      busy            <= 1'b0;
      done_pulse      <= 1'b0;
      err_pulse       <= 1'b0;
      timeout_pulse   <= 1'b0;
      missed_trig_cnt <= '0;
    end else begin
      state         <= state_nxt;
      req_valid     <= (state_nxt == REQUEST);
      busy          <= (state_nxt != IDLE);
      done_pulse    <= done_nxt;
      err_pulse     <= err_nxt;
      timeout_pulse <= tmo_nxt;
      if (state == SELECT && sel_found) begin
        ptr        <= sel_idx;
        req_bus_id <= sel_idx;
      end
      if (state == SELECT)
        timer <= '0;
      else if (state == REQUEST || state == WAIT_DONE)
        timer <= timer + 8'd1;
      if (request_trig && state != IDLE && missed_trig_cnt != 8'hFF)
        missed_trig_cnt <= missed_trig_cnt + 8'd1;
    end
  end

endmodule
